// File: rtl/axi_dma_pkg.sv
// Shared definitions for the 2D write-DMA engine: FSM encoding, AXI constants
// and a constant-evaluable ceiling log2.
package axi_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_AW    = 3'd2,
    ST_W     = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         BOUNDARY_4K = 4096;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Beat count for the next burst: the smallest of the beats left in the row,
// the burst length limit, and the beats that fit before the next 4 KB page.
module axi_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int C_BYTES_PER_BEAT = 4,
  parameter int C_BURST_LEN      = 16
) (
  input  logic [11:0] i_addr_lo,
  input  logic [31:0] i_row_beats_left,
  output logic [8:0]  o_beats
);

  localparam int C_SHIFT = clog2(C_BYTES_PER_BEAT);

  logic [12:0] w_room_bytes;
  logic [12:0] w_room_beats;
  logic [31:0] w_limit;

  // Bytes left in the current 4 KB page (1..4096); the address is beat aligned.
  assign w_room_bytes = 13'(BOUNDARY_4K) - {1'b0, i_addr_lo};
  assign w_room_beats = w_room_bytes >> C_SHIFT;

  // Three-way minimum of page room, burst limit and remaining row beats.
  always_comb begin
    w_limit = 32'(w_room_beats);
    if (32'(C_BURST_LEN) < w_limit) w_limit = 32'(C_BURST_LEN);
    if (i_row_beats_left < w_limit) w_limit = i_row_beats_left;
    o_beats = 9'(w_limit);
  end

endmodule

// File: rtl/axi_2d_write_master.sv
// 2D write-DMA engine: pulls words from a FWFT FIFO and writes a strided image
// through AXI4 INCR bursts that never cross a 4 KB page, with a bounded number
// of bursts awaiting their write response.
module axi_2d_write_master
  import axi_dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
  input  logic [31:0]                     i_img_width,
  input  logic [31:0]                     i_img_height,
  input  logic [31:0]                     i_img_stride,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_w_data,
  input  logic                            i_fifo_empty,
  output logic                            o_fifo_rd_en,
  output logic                            o_busy,
  output logic                            o_write_done,
  output logic                            o_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int C_AW         = C_M_AXI_ADDR_WIDTH;
  localparam int C_BPB        = C_M_AXI_DATA_WIDTH / 8;
  localparam int C_BEAT_SHIFT = clog2(C_BPB);
  localparam int C_PEND_W     = clog2(C_MAX_OUTSTANDING + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [C_AW-1:0]       r_addr;
  logic [C_AW-1:0]       r_row_base;
  logic [31:0]           r_stride;
  logic [31:0]           r_row_beats;
  logic [31:0]           r_row_beats_left;
  logic [31:0]           r_rows_left;
  logic [8:0]            r_beats;
  logic [8:0]            r_beat_cnt;
  logic [7:0]            r_awlen;
  logic [C_PEND_W-1:0]   r_pending;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [8:0]            w_beats;
  logic [31:0]           w_row_beats_start;
  logic                  w_zero_job;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_b_err;
  logic                  w_last_beat;
  logic                  w_burst_done;
  logic                  w_row_done;
  logic                  w_last_row;
  logic                  w_can_issue;
  logic [C_AW-1:0]       w_burst_bytes;
  logic [C_AW-1:0]       w_next_row_base;

  axi_burst_calc #(
    .C_BYTES_PER_BEAT (C_BPB),
    .C_BURST_LEN      (C_M_AXI_BURST_LEN)
  ) u_burst_calc (
    .i_addr_lo        (r_addr[11:0]),
    .i_row_beats_left (r_row_beats_left),
    .o_beats          (w_beats)
  );

  assign w_row_beats_start = i_img_width >> C_BEAT_SHIFT;
  assign w_zero_job        = (w_row_beats_start == 32'd0) || (i_img_height == 32'd0);

  assign w_aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_w_hs       = m_axi_wvalid & m_axi_wready;
  assign w_b_hs       = m_axi_bvalid & m_axi_bready;
  assign w_b_err      = w_b_hs && ((m_axi_bresp == RESP_SLVERR) || (m_axi_bresp == RESP_DECERR));
  assign w_last_beat  = (r_beat_cnt == (r_beats - 9'd1));
  assign w_burst_done = w_w_hs & w_last_beat;
  assign w_row_done   = (r_row_beats_left == 32'(r_beats));
  assign w_last_row   = (r_rows_left == 32'd1);
  assign w_can_issue  = (r_pending < C_PEND_W'(C_MAX_OUTSTANDING));

  assign w_burst_bytes   = C_AW'(r_beats) << C_BEAT_SHIFT;
  assign w_next_row_base = r_row_base + C_AW'(r_stride);

  // Constant or registered AXI fields.
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(C_BEAT_SHIFT);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wdata   = i_w_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = r_busy;
  assign o_busy        = r_busy;
  assign o_write_done  = r_done;
  assign o_error       = r_error;

  // FSM state register; reset aborts any transfer immediately.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_next = w_zero_job ? ST_DONE : ST_CALC;
      ST_CALC:  if (w_can_issue) w_state_next = ST_AW;
      ST_AW:    if (w_aw_hs) w_state_next = ST_W;
      ST_W: begin
        if (w_burst_done) w_state_next = (w_row_done && w_last_row) ? ST_DRAIN : ST_CALC;
      end
      ST_DRAIN: if (r_pending == '0) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: AW/W valids, last flag and the FIFO pop follow the state directly.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    if (r_state == ST_AW) m_axi_awvalid = 1'b1;
    if (r_state == ST_W) begin
      m_axi_wvalid = ~i_fifo_empty;
      m_axi_wlast  = w_last_beat;
    end
    o_fifo_rd_en = m_axi_wvalid & m_axi_wready;
  end

  // Job context, burst sizing and address walk.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_addr           <= '0;
      r_row_base       <= '0;
      r_stride         <= '0;
      r_row_beats      <= '0;
      r_row_beats_left <= '0;
      r_rows_left      <= '0;
      r_beats          <= '0;
      r_beat_cnt       <= '0;
      r_awlen          <= '0;
      r_busy           <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr           <= i_dst_addr;
            r_row_base       <= i_dst_addr;
            r_stride         <= i_img_stride;
            r_row_beats      <= w_row_beats_start;
            r_row_beats_left <= w_row_beats_start;
            r_rows_left      <= i_img_height;
            r_busy           <= 1'b1;
          end
        end
        ST_CALC: begin
          r_beats    <= w_beats;
          r_awlen    <= 8'(w_beats - 9'd1);
          r_beat_cnt <= '0;
        end
        ST_W: begin
          if (w_burst_done) begin
            r_beat_cnt <= '0;
            if (w_row_done) begin
              // Row finished: jump to the next row start and reload the row length.
              r_row_base       <= w_next_row_base;
              r_addr           <= w_next_row_base;
              r_row_beats_left <= r_row_beats;
              r_rows_left      <= r_rows_left - 32'd1;
            end else begin
              r_addr           <= r_addr + w_burst_bytes;
              r_row_beats_left <= r_row_beats_left - 32'(r_beats);
            end
          end else if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
          end
        end
        ST_DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Completion pulse lands on the same edge that drops busy.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_done <= 1'b0;
    else                r_done <= (r_state == ST_DONE);
  end

  // Bursts awaiting a write response; simultaneous issue and retire cancel.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_pending <= '0;
    end else begin
      unique case ({w_aw_hs, w_b_hs})
        2'b10:   r_pending <= r_pending + C_PEND_W'(1);
        2'b01:   r_pending <= r_pending - C_PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Sticky error: set by any SLVERR/DECERR, cleared only by an accepted start.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)                     r_error <= 1'b0;
    else if ((r_state == ST_IDLE) && i_start) r_error <= 1'b0;
    else if (w_b_err)                       r_error <= 1'b1;
  end

endmodule

// File: tb/tb_axi_2d_write_master.sv
// Scoreboard bench: jobs push expected AW bursts and W words into queues, an
// AXI slave/FIFO driver responds randomly, and a monitor pops and compares.
module tb_axi_2d_write_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BL  = 16;
  localparam int MO  = 4;
  localparam int BPB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_dst_addr = '0;
  logic [31:0]   i_img_width = '0, i_img_height = '0, i_img_stride = '0;
  logic [DW-1:0] i_w_data = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd_en, o_busy, o_write_done, o_error;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  always #5 clk = ~clk;

  axi_2d_write_master #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_M_AXI_BURST_LEN  (BL),
    .C_MAX_OUTSTANDING  (MO)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .i_start       (i_start),
    .i_dst_addr    (i_dst_addr),
    .i_img_width   (i_img_width),
    .i_img_height  (i_img_height),
    .i_img_stride  (i_img_stride),
    .i_w_data      (i_w_data),
    .i_fifo_empty  (i_fifo_empty),
    .o_fifo_rd_en  (o_fifo_rd_en),
    .o_busy        (o_busy),
    .o_write_done  (o_write_done),
    .o_error       (o_error),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_exp_t;

  aw_exp_t       exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [1:0]    b_q[$];
  int            burst_len_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int outstanding = 0;
  int beat_idx = 0;
  int burst_idx = 0;
  int aw_seen = 0;
  int err_idx = -1;
  logic [1:0] err_resp = 2'b10;
  bit b_hold = 1'b0;
  int empty_mode = 2;     // 0 random stalls, 1 toggle every cycle, 2 never stall
  int ready_pct = 100;
  bit toggle_ph = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: walk every row in plain byte arithmetic, cutting bursts at
  // the burst limit and at each 4 KB page edge.
  task automatic build_expect(input logic [AW-1:0] dst, input int width, input int height,
                              input logic [31:0] stride, output int nb);
    nb = 0;
    for (int r = 0; r < height; r++) begin
      logic [AW-1:0] a;
      int rem;
      a = dst + AW'(r) * stride;
      rem = width;
      while (rem > 0) begin
        int room;
        int n;
        aw_exp_t e;
        room = 4096 - int'(a % 4096);
        n = rem;
        if (n > BL * BPB) n = BL * BPB;
        if (n > room) n = room;
        e.addr = a;
        e.len = 8'(n / BPB - 1);
        exp_aw_q.push_back(e);
        a = a + AW'(n);
        rem = rem - n;
        nb++;
      end
    end
    for (int i = 0; i < (width / BPB) * height; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      exp_w_q.push_back(w);
    end
  endtask

  task automatic start_job(input logic [AW-1:0] dst, input int width, input int height,
                           input logic [31:0] stride, input int err, input logic [1:0] eresp,
                           output bit exp_err);
    int nb;
    burst_idx = 0;
    aw_seen = 0;
    err_idx = err;
    err_resp = eresp;
    build_expect(dst, width, height, stride, nb);
    exp_err = (err >= 0) && (err < nb) && eresp[1];
    $display("job dst=0x%08h width=%0d height=%0d stride=%0d bursts=%0d err_idx=%0d resp=%0b",
             dst, width, height, stride, nb, err, eresp);
    @(posedge clk); #1;
    i_dst_addr = dst;
    i_img_width = 32'(width);
    i_img_height = 32'(height);
    i_img_stride = stride;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", o_busy, 1);
    check("error_cleared_on_start", o_error, 0);
  endtask

  task automatic clear_bench_state();
    fifo_q.delete();
    exp_aw_q.delete();
    exp_w_q.delete();
    b_q.delete();
    burst_len_q.delete();
    outstanding = 0;
    beat_idx = 0;
    b_hold = 1'b0;
  endtask

  task automatic wait_done(input bit exp_err);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (o_write_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", got, 1);
    if (got) begin
      check("busy_low_at_done", o_busy, 0);
      check("aw_all_issued", exp_aw_q.size(), 0);
      check("w_all_sent", exp_w_q.size(), 0);
      check("fifo_drained", fifo_q.size(), 0);
      check("error_flag", o_error, exp_err);
      @(negedge clk);
      check("done_single_cycle", o_write_done, 0);
    end else begin
      // Recover from a stuck transfer so the run still reaches its summary.
      rst_n = 1'b0;
      clear_bench_state();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  // AXI slave and FIFO driver: handshakes seen at the falling edge take effect
  // at the rising edge; new input values are applied just after it.
  bit d_pop, d_aw, d_wl, d_b;
  always begin
    @(negedge clk);
    d_pop = o_fifo_rd_en;
    d_aw  = m_axi_awvalid & m_axi_awready;
    d_wl  = m_axi_wvalid & m_axi_wready & m_axi_wlast;
    d_b   = m_axi_bvalid & m_axi_bready;
    @(posedge clk); #1;
    if (!rst_n) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      i_fifo_empty  = 1'b1;
      i_w_data      = '0;
    end else begin
      if (d_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (d_aw) aw_seen++;
      if (d_wl) begin
        b_q.push_back((burst_idx == err_idx) ? err_resp : 2'($urandom_range(0, 1)));
        burst_idx++;
      end
      if (d_b && b_q.size() > 0) void'(b_q.pop_front());
      m_axi_awready = ($urandom_range(0, 99) < ready_pct);
      m_axi_wready  = ($urandom_range(0, 99) < ready_pct);
      toggle_ph = ~toggle_ph;
      case (empty_mode)
        0:       i_fifo_empty = (fifo_q.size() == 0) || ($urandom_range(0, 3) == 0);
        1:       i_fifo_empty = (fifo_q.size() == 0) || toggle_ph;
        default: i_fifo_empty = (fifo_q.size() == 0);
      endcase
      i_w_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (!(m_axi_bvalid && !d_b)) begin
        if (b_q.size() > 0 && !b_hold && $urandom_range(0, 1) == 1) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = b_q[0];
        end else begin
          m_axi_bvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every AW and W handshake against the scoreboard queues.
  always begin
    @(negedge clk);
    if (rst_n) begin
      if (m_axi_awvalid && m_axi_awready) begin
        check("aw_within_outstanding", outstanding < MO, 1);
        if (exp_aw_q.size() == 0) begin
          check("aw_unexpected", m_axi_awaddr, exp_aw_q.size());
        end else begin
          aw_exp_t e;
          e = exp_aw_q.pop_front();
          $display("AW addr=0x%08h len=%0d (exp 0x%08h len %0d)", m_axi_awaddr, m_axi_awlen, e.addr, e.len);
          check("aw_addr", m_axi_awaddr, e.addr);
          check("aw_len", m_axi_awlen, e.len);
          burst_len_q.push_back(int'(m_axi_awlen));
        end
        outstanding++;
      end
      if (o_busy) check("fifo_rd_en", o_fifo_rd_en, m_axi_wvalid & m_axi_wready);
      if (m_axi_wvalid) check("wvalid_needs_data", i_fifo_empty, 0);
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w_q.size() == 0 || burst_len_q.size() == 0) begin
          check("w_unexpected", (exp_w_q.size() > 0) && (burst_len_q.size() > 0), 1);
        end else begin
          check("w_data", m_axi_wdata, exp_w_q.pop_front());
          check("w_last", m_axi_wlast, beat_idx == burst_len_q[0]);
          if (beat_idx == burst_len_q[0]) begin
            void'(burst_len_q.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
      if (m_axi_bvalid && m_axi_bready) outstanding--;
    end
  end

  initial begin
    bit exp_err;
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs",
          {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, o_fifo_rd_en, o_busy, o_write_done, o_error, m_axi_bready}, 0);
    check("reset_awaddr", m_axi_awaddr, 0);
    check("reset_awlen", m_axi_awlen, 0);
    check("awsize_const", m_axi_awsize, 3'd2);
    check("awburst_const", m_axi_awburst, 2'b01);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two rows of one 16-beat burst each.
    empty_mode = 2; ready_pct = 100;
    start_job(32'h1000_0000, 64, 2, 32'd128, -1, 2'b00, exp_err);
    wait_done(exp_err);

    // Row straddling a 4 KB page.
    empty_mode = 0; ready_pct = 70;
    start_job(32'h0000_0FF0, 64, 1, 32'd64, -1, 2'b00, exp_err);
    wait_done(exp_err);

    // Outstanding limit: responses withheld until four bursts are in flight.
    empty_mode = 2; ready_pct = 100; b_hold = 1'b1;
    start_job(32'h2000_0000, 256, 2, 32'd256, 0, 2'b10, exp_err);
    for (int c = 0; c < 2000; c++) begin
      if (aw_seen >= MO && burst_idx >= MO) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("aw_blocked_at_max", aw_seen, MO);
    b_hold = 1'b0;
    wait_done(exp_err);

    // Zero-height job: completion two cycles after start, no AXI traffic.
    start_job(32'h3000_0000, 64, 0, 32'd64, -1, 2'b00, exp_err);
    check("zero_done_not_early", o_write_done, 0);
    @(negedge clk);
    check("zero_done_pulse", o_write_done, 1);
    check("zero_busy_low", o_busy, 0);
    @(negedge clk);
    check("zero_done_single", o_write_done, 0);

    // FIFO empty toggling every cycle.
    empty_mode = 1; ready_pct = 100;
    start_job(32'h0000_4000, 64, 2, 32'd100, 1, 2'b11, exp_err);
    wait_done(exp_err);

    // Address wrap at the top of the space.
    empty_mode = 0; ready_pct = 80;
    start_job(32'hFFFF_FFC0, 128, 1, 32'd128, -1, 2'b00, exp_err);
    wait_done(exp_err);

    // Randomised jobs.
    for (int j = 0; j < 8; j++) begin
      logic [AW-1:0] dst;
      int width;
      int height;
      logic [1:0] eresp;
      dst = ($urandom & 32'hFFFF_F000) | (32'h0000_0E00 + 32'(4 * $urandom_range(0, 127)));
      width = 4 * int'($urandom_range(1, 64));
      height = int'($urandom_range(1, 3));
      eresp = 2'($urandom_range(1, 3));
      empty_mode = int'($urandom_range(0, 2));
      ready_pct = int'($urandom_range(40, 100));
      start_job(dst, width, height, 32'(width + 4 * int'($urandom_range(0, 300))),
                int'($urandom_range(0, 7)) - 1, eresp, exp_err);
      wait_done(exp_err);
    end

    // Reset in the middle of a burst aborts everything at once.
    empty_mode = 0; ready_pct = 90;
    start_job(32'h5000_0000, 256, 4, 32'd512, -1, 2'b00, exp_err);
    for (int c = 0; c < 2000; c++) begin
      if (aw_seen >= 2 && m_axi_wvalid) break;
      @(negedge clk);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl_outputs",
          {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, o_fifo_rd_en, o_busy, o_write_done, o_error, m_axi_bready}, 0);
    check("midreset_awaddr", m_axi_awaddr, 0);
    check("midreset_awlen", m_axi_awlen, 0);
    clear_bench_state();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {o_busy, m_axi_awvalid}, 0);

    // Recovery job after the abort.
    start_job(32'h0000_0F80, 192, 2, 32'd4096, 2, 2'b10, exp_err);
    wait_done(exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
